// File: rtl/cg_iteration_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : cg_iteration_sequencer
//  Purpose  : Control sequencer for a conjugate-gradient solver. Walks the
//             r.r / A.p / divide / update stages of each CG iteration, holds
//             the scalar state (rs_old, rs_new, alpha, beta), checks the
//             residual against the tolerance and guards each stage with a
//             watchdog.
//  Revision : 1.0 - initial release
// ============================================================================
module cg_iteration_sequencer #(
  parameter int ELEMENT_WIDTH = 32,
  parameter int ITER_WIDTH    = 16,
  parameter int WD_CYCLES     = 65535
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [ITER_WIDTH-1:0]    max_iter,
  input  logic [ELEMENT_WIDTH-1:0] tolerance,
  output logic [4:0]               stage_start,
  input  logic [4:0]               stage_done,
  input  logic [ELEMENT_WIDTH-1:0] dot_result,
  input  logic [ELEMENT_WIDTH-1:0] div_result,
  output logic [ELEMENT_WIDTH-1:0] div_num,
  output logic [ELEMENT_WIDTH-1:0] div_den,
  output logic [ELEMENT_WIDTH-1:0] alpha,
  output logic [ELEMENT_WIDTH-1:0] beta,
  output logic [ITER_WIDTH-1:0]    iter_count,
  output logic                     busy,
  output logic                     done,
  output logic                     converged,
  output logic                     timeout
);

  // Stage one-hot codes driven on stage_start / matched on stage_done
  localparam logic [4:0] c_STG_RR  = 5'b00001;
  localparam logic [4:0] c_STG_AP  = 5'b00010;
  localparam logic [4:0] c_STG_DIV = 5'b00100;
  localparam logic [4:0] c_STG_XR  = 5'b01000;
  localparam logic [4:0] c_STG_P   = 5'b10000;

  // Watchdog sizing: counter just wide enough to reach WD_CYCLES
  localparam logic              c_WD_EN    = (WD_CYCLES != 0);
  localparam int                c_WD_W     = (WD_CYCLES > 1) ? $clog2(WD_CYCLES + 1) : 1;
  localparam logic [c_WD_W-1:0] c_WD_LIMIT = c_WD_W'(WD_CYCLES);
  localparam logic [c_WD_W-1:0] c_WD_ONE   = c_WD_W'(1);
  localparam logic [ITER_WIDTH-1:0] c_ITER_ONE = ITER_WIDTH'(1);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_RS0    = 4'd1,
    S_AP     = 4'd2,
    S_ALPHA  = 4'd3,
    S_UPD_XR = 4'd4,
    S_RSNEW  = 4'd5,
    S_BETA   = 4'd6,
    S_UPD_P  = 4'd7,
    S_FINISH = 4'd8
  } state_t;

  state_t                   r_state;
  logic [ITER_WIDTH-1:0]    r_max_iter;
  logic [ELEMENT_WIDTH-1:0] r_tol;
  logic [ELEMENT_WIDTH-1:0] r_rsold;
  logic [ELEMENT_WIDTH-1:0] r_rsnew;
  logic [c_WD_W-1:0]        r_wd;

  logic                     w_in_stage;
  logic                     w_done_hit;
  logic                     w_done_ok;
  logic                     w_wd_expire;
  logic                     w_dot_le_tol;
  logic [c_WD_W-1:0]        w_wd_next;
  logic [ITER_WIDTH-1:0]    w_iter_inc;

  // Select the one stage_done bit that belongs to the current stage state
  always_comb begin
    w_in_stage = 1'b1;
    w_done_hit = 1'b0;
    case (r_state)
      S_RS0, S_RSNEW: w_done_hit = stage_done[0];
      S_AP:           w_done_hit = stage_done[1];
      S_ALPHA, S_BETA: w_done_hit = stage_done[2];
      S_UPD_XR:       w_done_hit = stage_done[3];
      S_UPD_P:        w_done_hit = stage_done[4];
      default:        w_in_stage = 1'b0;
    endcase
  end

  // A done is only honoured after the start-pulse cycle of the stage
  assign w_done_ok    = w_in_stage && (stage_start == 5'b00000) && w_done_hit;
  assign w_wd_next    = r_wd + c_WD_ONE;
  // A done in the same cycle wins over the watchdog expiring
  assign w_wd_expire  = c_WD_EN && w_in_stage && !w_done_ok && (w_wd_next == c_WD_LIMIT);
  assign w_iter_inc   = iter_count + c_ITER_ONE;
  // Unsigned bit-pattern compare is monotonic for non-negative IEEE-754 values
  assign w_dot_le_tol = (dot_result <= r_tol);

  // Sequencer: state, stage pulses, operands, coefficients and status flags
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      stage_start <= 5'b00000;
      done        <= 1'b0;
      busy        <= 1'b0;
      converged   <= 1'b0;
      timeout     <= 1'b0;
      alpha       <= '0;
      beta        <= '0;
      iter_count  <= '0;
      div_num     <= '0;
      div_den     <= '0;
      r_max_iter  <= '0;
      r_tol       <= '0;
      r_rsold     <= '0;
      r_rsnew     <= '0;
      r_wd        <= '0;
    end else begin
      stage_start <= 5'b00000;
      done        <= 1'b0;
      // Watchdog restarts on every state change and runs only inside a stage
      r_wd        <= (w_in_stage && !w_done_ok) ? w_wd_next : '0;

      if (w_wd_expire) begin
        timeout <= 1'b1;
        done    <= 1'b1;
        r_state <= S_FINISH;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              r_max_iter  <= max_iter;
              r_tol       <= tolerance;
              iter_count  <= '0;
              converged   <= 1'b0;
              timeout     <= 1'b0;
              busy        <= 1'b1;
              stage_start <= c_STG_RR;
              r_state     <= S_RS0;
            end
          end

          S_RS0: begin
            if (w_done_ok) begin
              r_rsold <= dot_result;
              if (w_dot_le_tol || (r_max_iter == '0)) begin
                converged <= w_dot_le_tol;
                done      <= 1'b1;
                r_state   <= S_FINISH;
              end else begin
                stage_start <= c_STG_AP;
                r_state     <= S_AP;
              end
            end
          end

          S_AP: begin
            // p.Ap goes straight into the divider denominator, which is
            // where the value is needed and held for the whole ALPHA stage
            if (w_done_ok) begin
              div_num     <= r_rsold;
              div_den     <= dot_result;
              stage_start <= c_STG_DIV;
              r_state     <= S_ALPHA;
            end
          end

          S_ALPHA: begin
            if (w_done_ok) begin
              alpha       <= div_result;
              stage_start <= c_STG_XR;
              r_state     <= S_UPD_XR;
            end
          end

          S_UPD_XR: begin
            if (w_done_ok) begin
              stage_start <= c_STG_RR;
              r_state     <= S_RSNEW;
            end
          end

          S_RSNEW: begin
            if (w_done_ok) begin
              r_rsnew <= dot_result;
              if (w_dot_le_tol) begin
                iter_count <= w_iter_inc;
                converged  <= 1'b1;
                done       <= 1'b1;
                r_state    <= S_FINISH;
              end else begin
                div_num     <= dot_result;
                div_den     <= r_rsold;
                stage_start <= c_STG_DIV;
                r_state     <= S_BETA;
              end
            end
          end

          S_BETA: begin
            if (w_done_ok) begin
              beta        <= div_result;
              stage_start <= c_STG_P;
              r_state     <= S_UPD_P;
            end
          end

          S_UPD_P: begin
            if (w_done_ok) begin
              r_rsold    <= r_rsnew;
              iter_count <= w_iter_inc;
              if (w_iter_inc == r_max_iter) begin
                converged <= 1'b0;
                done      <= 1'b1;
                r_state   <= S_FINISH;
              end else begin
                stage_start <= c_STG_AP;
                r_state     <= S_AP;
              end
            end
          end

          S_FINISH: begin
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end

          default: begin
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cg_iteration_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_cg_iteration_sequencer
//  Purpose  : Self-checking bench for cg_iteration_sequencer. A table of
//             per-stage records (expected stage, expected divider operands,
//             result to return) drives a stub datapath; hand sequences cover
//             the watchdog, spurious done/start and mid-solve reset.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cg_iteration_sequencer;

  localparam logic [31:0] c_TOL = 32'h283424DC;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] max_iter = '0;
  logic [31:0] tolerance = '0;
  logic [4:0]  stage_done = '0;
  logic [31:0] dot_result = '0;
  logic [31:0] div_result = '0;
  logic [4:0]  stage_start;
  logic [31:0] div_num, div_den, alpha, beta;
  logic [15:0] iter_count;
  logic        busy, done, converged, timeout;

  cg_iteration_sequencer #(
    .ELEMENT_WIDTH(32),
    .ITER_WIDTH   (16),
    .WD_CYCLES    (10)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .max_iter   (max_iter),
    .tolerance  (tolerance),
    .stage_start(stage_start),
    .stage_done (stage_done),
    .dot_result (dot_result),
    .div_result (div_result),
    .div_num    (div_num),
    .div_den    (div_den),
    .alpha      (alpha),
    .beta       (beta),
    .iter_count (iter_count),
    .busy       (busy),
    .done       (done),
    .converged  (converged),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          stage;
    logic        chk_div;
    logic [31:0] num;
    logic [31:0] den;
    logic [31:0] res;
  } row_t;

  row_t rows [26];
  int   checks = 0;
  int   failures = 0;
  int   pulse_cnt [5] = '{default: 0};
  int   done_cnt = 0;
  int   snap [5];
  int   snap_done;

  // Count stage_start pulses per bit and done pulses
  always @(negedge clk) begin
    for (int b = 0; b < 5; b++)
      if (stage_start[b]) pulse_cnt[b] <= pulse_cnt[b] + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  function automatic row_t mk(input int s, input logic c, input logic [31:0] n,
                              input logic [31:0] d, input logic [31:0] r);
    row_t t;
    t.stage = s; t.chk_div = c; t.num = n; t.den = d; t.res = r;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic take_snap();
    for (int b = 0; b < 5; b++) snap[b] = pulse_cnt[b];
    snap_done = done_cnt;
  endtask

  function automatic int delta(input int b);
    return pulse_cnt[b] - snap[b];
  endfunction

  function automatic int delta_all();
    int s = 0;
    for (int b = 0; b < 5; b++) s += pulse_cnt[b] - snap[b];
    return s;
  endfunction

  // Returns index of the one-hot stage_start bit, 99 if not one-hot, 98 on expiry
  task automatic wait_pulse(output int got);
    got = 98;
    for (int n = 0; n < 40; n++) begin
      if (stage_start != 5'b00000) begin
        got = 99;
        for (int b = 0; b < 5; b++)
          if (stage_start == (5'b00001 << b)) got = b;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_done(input string name);
    logic seen;
    seen = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check({name, "_done_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic do_start(input logic [15:0] mi, input logic [31:0] tol);
    @(negedge clk);
    start = 1'b1; max_iter = mi; tolerance = tol;
    @(negedge clk);
    // Scramble the inputs so only latched values can give the right answers
    start = 1'b0; max_iter = 16'hFFFF; tolerance = 32'h0;
  endtask

  // Apply table rows: expect the stage pulse, check divider operands, answer
  task automatic run_rows(input int first, input int last);
    int got;
    for (int i = first; i <= last; i++) begin
      wait_pulse(got);
      check($sformatf("row%0d_stage", i), 32'(got), 32'(rows[i].stage));
      if (rows[i].chk_div) begin
        check($sformatf("row%0d_div_num", i), div_num, rows[i].num);
        check($sformatf("row%0d_div_den", i), div_den, rows[i].den);
      end
      @(negedge clk);
      @(negedge clk);
      stage_done = 5'b00001 << rows[i].stage;
      dot_result = rows[i].res;
      div_result = rows[i].res;
      @(negedge clk);
      stage_done = 5'b00000;
    end
  endtask

  task automatic check_all_zero(input string p);
    check({p, "_stage_start"}, 32'(stage_start), 32'd0);
    check({p, "_done"}, 32'(done), 32'd0);
    check({p, "_busy"}, 32'(busy), 32'd0);
    check({p, "_converged"}, 32'(converged), 32'd0);
    check({p, "_timeout"}, 32'(timeout), 32'd0);
    check({p, "_alpha"}, alpha, 32'd0);
    check({p, "_beta"}, beta, 32'd0);
    check({p, "_iter"}, 32'(iter_count), 32'd0);
    check({p, "_div_num"}, div_num, 32'd0);
    check({p, "_div_den"}, div_den, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1, "bench hung");
  end

  initial begin
    int got;
    int k;
    int tcyc;

    // Three-iteration non-converging solve (rows 0..18)
    rows[0]  = mk(0, 0, 0, 0, 32'h41000000);
    rows[1]  = mk(1, 0, 0, 0, 32'h40800000);
    rows[2]  = mk(2, 1, 32'h41000000, 32'h40800000, 32'h3F000000);
    rows[3]  = mk(3, 0, 0, 0, 32'h00000000);
    rows[4]  = mk(0, 0, 0, 0, 32'h40400000);
    rows[5]  = mk(2, 1, 32'h40400000, 32'h41000000, 32'h3F400000);
    rows[6]  = mk(4, 0, 0, 0, 32'h00000000);
    rows[7]  = mk(1, 0, 0, 0, 32'h40000000);
    rows[8]  = mk(2, 1, 32'h40400000, 32'h40000000, 32'h3FC00000);
    rows[9]  = mk(3, 0, 0, 0, 32'h00000000);
    rows[10] = mk(0, 0, 0, 0, 32'h3F800000);
    rows[11] = mk(2, 1, 32'h3F800000, 32'h40400000, 32'h3EAAAAAB);
    rows[12] = mk(4, 0, 0, 0, 32'h00000000);
    rows[13] = mk(1, 0, 0, 0, 32'h3F000000);
    rows[14] = mk(2, 1, 32'h3F800000, 32'h3F000000, 32'h40000000);
    rows[15] = mk(3, 0, 0, 0, 32'h00000000);
    rows[16] = mk(0, 0, 0, 0, 32'h3E800000);
    rows[17] = mk(2, 1, 32'h3E800000, 32'h3F800000, 32'h3E800000);
    rows[18] = mk(4, 0, 0, 0, 32'h00000000);
    // Converging r_new in iteration 2
    rows[19] = mk(0, 0, 0, 0, 32'h28000000);
    // Single-row RS0 cases: zero residual, equal to tolerance, large
    rows[20] = mk(0, 0, 0, 0, 32'h00000000);
    rows[21] = mk(0, 0, 0, 0, c_TOL);
    rows[22] = mk(0, 0, 0, 0, 32'h7F000000);
    // Just above tolerance, then into the update stage for the reset test
    rows[23] = mk(0, 0, 0, 0, 32'h283424DD);
    rows[24] = mk(1, 0, 0, 0, 32'h40800000);
    rows[25] = mk(2, 1, 32'h283424DD, 32'h40800000, 32'h3E000000);

    // Reset state
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);
    check_all_zero("post_reset_idle");

    // Full three-iteration run
    take_snap();
    do_start(16'd3, c_TOL);
    check("a_busy", 32'(busy), 32'd1);
    run_rows(0, 18);
    wait_done("a");
    check("a_iter", 32'(iter_count), 32'd3);
    check("a_converged", 32'(converged), 32'd0);
    check("a_timeout", 32'(timeout), 32'd0);
    check("a_alpha", alpha, 32'h40000000);
    check("a_beta", beta, 32'h3E800000);
    @(negedge clk);
    check("a_done_one_cycle", 32'(done), 32'd0);
    check("a_idle_busy", 32'(busy), 32'd0);
    check("a_done_pulses", 32'(done_cnt - snap_done), 32'd1);
    check("a_pulses_rr", 32'(delta(0)), 32'd4);
    check("a_pulses_ap", 32'(delta(1)), 32'd3);
    check("a_pulses_div", 32'(delta(2)), 32'd6);
    check("a_pulses_xr", 32'(delta(3)), 32'd3);
    check("a_pulses_p", 32'(delta(4)), 32'd3);
    repeat (3) @(negedge clk);
    check("a_iter_hold", 32'(iter_count), 32'd3);

    // Zero initial residual: finish straight from RS0
    take_snap();
    do_start(16'd5, c_TOL);
    run_rows(20, 20);
    wait_done("b");
    check("b_converged", 32'(converged), 32'd1);
    check("b_iter", 32'(iter_count), 32'd0);
    check("b_no_ap", 32'(delta(1)), 32'd0);
    @(negedge clk);
    check("b_converged_hold", 32'(converged), 32'd1);

    // Residual exactly equal to tolerance counts as converged
    do_start(16'd5, c_TOL);
    run_rows(21, 21);
    wait_done("c");
    check("c_converged", 32'(converged), 32'd1);
    check("c_iter", 32'(iter_count), 32'd0);

    // max_iter of zero finishes without iterating; start clears converged
    take_snap();
    do_start(16'd0, c_TOL);
    check("d_converged_cleared", 32'(converged), 32'd0);
    run_rows(22, 22);
    wait_done("d");
    check("d_converged", 32'(converged), 32'd0);
    check("d_iter", 32'(iter_count), 32'd0);
    check("d_no_ap", 32'(delta(1)), 32'd0);

    // Convergence on r_new in the second iteration: no BETA entry
    take_snap();
    do_start(16'd5, c_TOL);
    run_rows(0, 9);
    run_rows(19, 19);
    wait_done("e");
    check("e_converged", 32'(converged), 32'd1);
    check("e_iter", 32'(iter_count), 32'd2);
    check("e_alpha", alpha, 32'h3FC00000);
    check("e_beta", beta, 32'h3F400000);
    check("e_div_pulses", 32'(delta(2)), 32'd3);
    check("e_p_pulses", 32'(delta(4)), 32'd1);

    // Watchdog on AP, with done-in-pulse-cycle, foreign done and start ignored
    do_start(16'd4, c_TOL);
    run_rows(22, 22);
    wait_pulse(got);
    check("f_ap_stage", 32'(got), 32'd1);
    stage_done = 5'b00010;
    k = 0;
    tcyc = -1;
    while (k < 30) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        stage_done = 5'b00000;
        take_snap();
      end
      if (k == 3) begin
        stage_done = 5'b10000;
        start = 1'b1;
      end
      if (k == 4) begin
        stage_done = 5'b00000;
        start = 1'b0;
      end
      if (timeout) begin
        tcyc = k;
        break;
      end
    end
    stage_done = 5'b00000;
    start = 1'b0;
    check("f_timeout_cycle", 32'(tcyc), 32'd10);
    check("f_done_with_timeout", 32'(done), 32'd1);
    check("f_converged", 32'(converged), 32'd0);
    check("f_iter", 32'(iter_count), 32'd0);
    check("f_no_stage_change", 32'(delta_all()), 32'd0);
    @(negedge clk);
    check("f_idle", 32'(busy), 32'd0);
    check("f_timeout_hold", 32'(timeout), 32'd1);

    // Reset while in UPD_XR aborts, late done is ignored
    do_start(16'd5, c_TOL);
    check("g_timeout_cleared", 32'(timeout), 32'd0);
    run_rows(23, 25);
    wait_pulse(got);
    check("g_xr_stage", 32'(got), 32'd3);
    check("g_alpha_loaded", alpha, 32'h3E000000);
    reset = 1'b1;
    @(negedge clk);
    check_all_zero("g_reset");
    reset = 1'b0;
    take_snap();
    stage_done = 5'b01000;
    @(negedge clk);
    stage_done = 5'b00000;
    repeat (4) @(negedge clk);
    check("g_stays_idle", 32'(busy), 32'd0);
    check("g_no_pulses", 32'(delta_all()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
